// File: rtl/timer_pkg.sv
// Shared types and constants for the shared-timer programming arbiter.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CFG  = 3'd1,
    MSB  = 3'd2,
    LSB  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int unsigned CFG_RUN_BIT   = 7;
  localparam int unsigned CFG_MODE_BIT  = 6;
  localparam int unsigned CFG_PRESC_MSB = 5;
  localparam int unsigned CFG_PRESC_LSB = 0;

  localparam int unsigned CFG_W    = 8;
  localparam int unsigned RELOAD_W = 16;

endpackage

// File: rtl/timer_access_arbiter_rr_arbiter.sv
// Round-robin request picker: first requester searching upward from last+1.
module rr_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_valid
);

  logic [IDX_W-1:0] cand;

  // Walk the candidates in priority order, keep the first one that requests.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      cand = IDX_W'((32'(last) + i) % NUM_CORES);
      if (!gnt_valid && req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_access_arbiter.sv
// Shares one timer among several cores: arbitrates program requests, runs the
// byte-wide write sequence and routes overflow edges to the current owner.
module timer_access_arbiter
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                          CLK,
  input  logic                          CPU_Reset,
  input  logic [NUM_CORES-1:0]          REQ,
  input  logic [CFG_W*NUM_CORES-1:0]    REQ_CONFIG,
  input  logic [RELOAD_W*NUM_CORES-1:0] REQ_RELOAD,
  output logic [NUM_CORES-1:0]          ACK,
  output logic                          BUSY,
  output logic [IDX_W-1:0]              OWNER,
  output logic                          OWNER_VALID,
  output logic [NUM_CORES-1:0]          OV_FLAG,
  input  logic [NUM_CORES-1:0]          OV_CLR,
  output logic                          TIMER_EN,
  output logic                          TIMER_SET_REGISTER,
  output logic                          TIMER_WR_MSB,
  output logic                          TIMER_WR_LSB,
  output logic [7:0]                    TIMER_DATA,
  input  logic                          TIMER_OV
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [CFG_W-1:0]      cfg_q, cfg_d;
  logic [RELOAD_W-1:0]   reload_q, reload_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic                  owner_valid_q, owner_valid_d;
  logic [NUM_CORES-1:0]  ov_flag_q, ov_flag_d;
  logic                  ov_prev_q, ov_prev_d;
  logic [NUM_CORES-1:0]  ack_q, ack_d;
  logic                  en_q, en_d;
  logic                  set_q, set_d;
  logic                  msb_q, msb_d;
  logic                  lsb_q, lsb_d;
  logic [7:0]            data_q, data_d;

  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_valid;
  logic                  ov_edge;
  logic [NUM_CORES-1:0]  ov_set;
  logic [NUM_CORES-1:0]  ov_clr;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .req       (REQ),
    .last      (last_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Next state, payload latches and next-cycle output values; flag set beats clear.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = grant_q;
    cfg_d         = cfg_q;
    reload_d      = reload_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    ov_prev_d     = TIMER_OV;
    ack_d         = '0;
    en_d          = 1'b0;
    set_d         = 1'b0;
    msb_d         = 1'b0;
    lsb_d         = 1'b0;
    data_d        = '0;
    ov_set        = '0;
    ov_clr        = OV_CLR;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d  = CFG;
          grant_d  = gnt_idx;
          last_d   = gnt_idx;
          cfg_d    = REQ_CONFIG[CFG_W*32'(gnt_idx) +: CFG_W];
          reload_d = REQ_RELOAD[RELOAD_W*32'(gnt_idx) +: RELOAD_W];
          en_d     = 1'b1;
          set_d    = 1'b1;
          data_d   = REQ_CONFIG[CFG_W*32'(gnt_idx) +: CFG_W];
        end
      end
      CFG: begin
        state_d = MSB;
        en_d    = 1'b1;
        msb_d   = 1'b1;
        data_d  = reload_q[15:8];
      end
      MSB: begin
        state_d = LSB;
        en_d    = 1'b1;
        lsb_d   = 1'b1;
        data_d  = reload_q[7:0];
      end
      LSB: begin
        state_d        = DONE;
        ack_d[grant_q] = 1'b1;
        owner_d        = grant_q;
        owner_valid_d  = 1'b1;
      end
      DONE: begin
        state_d         = IDLE;
        ov_clr[grant_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    ov_edge = TIMER_OV & ~ov_prev_q;
    if (ov_edge && owner_valid_q && !(state_q inside {CFG, MSB, LSB})) begin
      ov_set[owner_q] = 1'b1;
    end
    ov_flag_d = (ov_flag_q & ~ov_clr) | ov_set;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      state_q       <= IDLE;
      last_q        <= IDX_W'(NUM_CORES - 1);
      grant_q       <= '0;
      cfg_q         <= '0;
      reload_q      <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      ov_flag_q     <= '0;
      ov_prev_q     <= 1'b0;
      ack_q         <= '0;
      en_q          <= 1'b0;
      set_q         <= 1'b0;
      msb_q         <= 1'b0;
      lsb_q         <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      cfg_q         <= cfg_d;
      reload_q      <= reload_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      ov_flag_q     <= ov_flag_d;
      ov_prev_q     <= ov_prev_d;
      ack_q         <= ack_d;
      en_q          <= en_d;
      set_q         <= set_d;
      msb_q         <= msb_d;
      lsb_q         <= lsb_d;
      data_q        <= data_d;
    end
  end

  assign BUSY               = (state_q != IDLE);
  assign ACK                = ack_q;
  assign OWNER              = owner_q;
  assign OWNER_VALID        = owner_valid_q;
  assign OV_FLAG            = ov_flag_q;
  assign TIMER_EN           = en_q;
  assign TIMER_SET_REGISTER = set_q;
  assign TIMER_WR_MSB       = msb_q;
  assign TIMER_WR_LSB       = lsb_q;
  assign TIMER_DATA         = data_q;

endmodule
